uart_hd_line_arbiter: RTL and testbench

//  Arbitrates two local byte requesters onto one shared half-duplex UART wire and serializes each granted byte as an
//  8N1 frame. Owns line direction (line_oe) and inserts a released-line guard interval after every frame.

---
 rtl/uart_hd_line_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_hd_line_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hd_line_arbiter.sv
// Half-duplex UART line arbiter: round-robin grant between two byte
// requesters, 8N1 serialization, line direction control and post-frame guard.
module uart_hd_line_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned GUARD_BITS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] din0,
  output logic       ack0,
  output logic       done0,
  input  logic       req1,
  input  logic [7:0] din1,
  output logic       ack1,
  output logic       done1,
  input  logic       rx_busy,
  output logic       line_tx,
  output logic       line_oe,
  output logic       owner,
  output logic       busy
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned GW = (GUARD_BITS > 0) ? $clog2(GUARD_BITS + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GUARD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          grant;
  logic          winner;
  logic          bit_end;

  // Next-state, counters, latching and pulse generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    gcnt_d  = gcnt_q;
    shreg_d = shreg_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    bit_end = (cnt_q == CNT_LAST);
    // The done cycle is a mandatory idle cycle: no grant is taken on it,
    // so the next ack lands two cycles after done.
    grant   = (req0 | req1) & ~rx_busy & ~(done0_q | done1_q);
    winner  = (req0 & req1) ? ~last_q : req1;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_START;
          cnt_d   = '0;
          shreg_d = winner ? din1 : din0;
          owner_d = winner;
          last_d  = winner;
          ack0_d  = ~winner;
          ack1_d  = winner;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d  = '0;
          gcnt_d = '0;
          if (GUARD_BITS == 0) begin
            state_d = S_IDLE;
            done0_d = ~owner_q;
            done1_d = owner_q;
          end else begin
            state_d = S_GUARD;
          end
        end
      end
      S_GUARD: begin
        cnt_d = cnt_q + CW'(1);
        if (bit_end) begin
          cnt_d  = '0;
          gcnt_d = gcnt_q + GW'(1);
          if (gcnt_q == GUARD_LAST) begin
            state_d = S_IDLE;
            done0_d = ~owner_q;
            done1_d = owner_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      gcnt_q  <= '0;
      shreg_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      gcnt_q  <= gcnt_d;
      shreg_q <= shreg_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  // Pad drive: line held only for start/data/stop, released (high) otherwise
  always_comb begin
    line_tx = 1'b1;
    line_oe = 1'b0;
    case (state_q)
      S_START: begin
        line_tx = 1'b0;
        line_oe = 1'b1;
      end
      S_DATA: begin
        line_tx = shreg_q[0];
        line_oe = 1'b1;
      end
      S_STOP: line_oe = 1'b1;
      default: ;
    endcase
  end

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_hd_line_arbiter.sv
// Bench for uart_hd_line_arbiter: directed table, hand sequences for the
// multi-cycle corners, and random stimulus against a frame-offset model.
module tb_uart_hd_line_arbiter;

  localparam int C  = 4;
  localparam int G  = 2;
  localparam int F  = (10 + G) * C;
  localparam int F0 = 10 * C;

  logic       clk;
  logic       rst;
  logic       req0, req1, rx_busy;
  logic [7:0] din0, din1;
  logic       ack0, ack1, done0, done1, line_tx, line_oe, owner, busy;

  logic       b_req0, b_req1, b_rx_busy;
  logic [7:0] b_din0, b_din1;
  logic       b_ack0, b_ack1, b_done0, b_done1, b_line_tx, b_line_oe, b_owner, b_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  uart_hd_line_arbiter #(.CLKS_PER_BIT(C), .GUARD_BITS(G)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .ack0(ack0), .done0(done0),
    .req1(req1), .din1(din1), .ack1(ack1), .done1(done1),
    .rx_busy(rx_busy), .line_tx(line_tx), .line_oe(line_oe),
    .owner(owner), .busy(busy)
  );

  uart_hd_line_arbiter #(.CLKS_PER_BIT(C), .GUARD_BITS(0)) dut_g0 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .din0(b_din0), .ack0(b_ack0), .done0(b_done0),
    .req1(b_req1), .din1(b_din1), .ack1(b_ack1), .done1(b_done1),
    .rx_busy(b_rx_busy), .line_tx(b_line_tx), .line_oe(b_line_oe),
    .owner(b_owner), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] outs();
    return {ack0, ack1, done0, done1, line_tx, line_oe, owner, busy};
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return ack0;
      1: return ack1;
      2: return done0;
      3: return done1;
      4: return b_ack0;
      5: return b_done0;
      default: return ack0 | ack1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, input string name, output int ok, output int ts);
    ok = 0;
    ts = -1;
    for (int i = 0; i < budget && ok == 0; i++) begin
      step();
      if (sig(sel)) begin
        ok = 1;
        ts = cyc;
      end
    end
    if (ok == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rx_busy = 1'b0; din0 = '0; din1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_rx_busy = 1'b0; b_din0 = '0; b_din1 = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Called on the ack cycle (offset 0); walks the frame through the done cycle.
  task automatic capture(input int clr_at, output logic [9:0] frame, output int oe_cnt,
                         output int done_t, output int done_who, output int extra_ack);
    frame = '0;
    oe_cnt = 0;
    done_t = -1;
    done_who = -1;
    extra_ack = 0;
    for (int t = 0; t <= F + 1; t++) begin
      if (t == clr_at) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      if (t < F && line_oe) oe_cnt++;
      if ((t % C) == C / 2 && (t / C) < 10) frame[t / C] = line_tx;
      if (t > 0 && (ack0 | ack1)) extra_ack++;
      if (done_t < 0 && (done0 | done1)) begin
        done_t = t;
        done_who = done1 ? 1 : 0;
      end
      if (t < F + 1) step();
    end
  endtask

  typedef struct {
    logic       r0;
    logic [7:0] d0;
    logic       r1;
    logic [7:0] d1;
    int         exp_own;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t tbl[5];

  // Reference model: a frame is described only by its offset from the ack cycle.
  int         m_act, m_t, m_own, m_last, m_done;
  logic [7:0] m_byte;

  function automatic logic [7:0] model_out();
    logic [7:0] o;
    int b;
    if (m_act != 0) begin
      b = m_t / C;
      o[7] = (m_t == 0) && (m_own == 0);
      o[6] = (m_t == 0) && (m_own == 1);
      o[5] = 1'b0;
      o[4] = 1'b0;
      o[3] = (b == 0) ? 1'b0 : (b <= 8) ? m_byte[b - 1] : 1'b1;
      o[2] = (b <= 9);
      o[1] = m_own[0];
      o[0] = 1'b1;
    end else begin
      o[7] = 1'b0;
      o[6] = 1'b0;
      o[5] = (m_done != 0) && (m_own == 0);
      o[4] = (m_done != 0) && (m_own == 1);
      o[3] = 1'b1;
      o[2] = 1'b0;
      o[1] = m_own[0];
      o[0] = 1'b0;
    end
    return o;
  endfunction

  task automatic model_reset();
    m_act = 0; m_t = 0; m_own = 0; m_last = 1; m_done = 0; m_byte = '0;
  endtask

  task automatic model_adv(input logic r, input logic r0, input logic r1,
                           input logic [7:0] d0, input logic [7:0] d1, input logic rb);
    int w;
    if (r) begin
      model_reset();
    end else if (m_act != 0) begin
      m_t++;
      if (m_t == F) begin
        m_act = 0;
        m_done = 1;
      end
    end else if (m_done != 0) begin
      m_done = 0;
    end else if ((r0 || r1) && !rb) begin
      w = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
      m_act = 1;
      m_t = 0;
      m_own = w;
      m_last = w;
      m_byte = (w == 1) ? d1 : d0;
    end
  endtask

  initial begin
    logic [9:0] frame;
    int ok, ta, td, ta2, td2, oe_cnt, done_t, done_who, extra, cnt, gap;

    tbl[0] = '{r0: 1'b1, d0: 8'hA5, r1: 1'b0, d1: 8'h00, exp_own: 0, exp_byte: 8'hA5};
    tbl[1] = '{r0: 1'b0, d0: 8'h00, r1: 1'b1, d1: 8'h3C, exp_own: 1, exp_byte: 8'h3C};
    tbl[2] = '{r0: 1'b1, d0: 8'h11, r1: 1'b1, d1: 8'h22, exp_own: 0, exp_byte: 8'h11};
    tbl[3] = '{r0: 1'b1, d0: 8'hFF, r1: 1'b0, d1: 8'h00, exp_own: 0, exp_byte: 8'hFF};
    tbl[4] = '{r0: 1'b0, d0: 8'h77, r1: 1'b1, d1: 8'h80, exp_own: 1, exp_byte: 8'h80};

    do_reset();
    chk("reset_outs", {24'd0, outs()}, 32'h08);
    chk("reset_outs_g0", {24'd0, b_ack0, b_ack1, b_done0, b_done1, b_line_tx, b_line_oe, b_owner, b_busy}, 32'h08);

    // Directed single-frame table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      req0 = tbl[i].r0; din0 = tbl[i].d0;
      req1 = tbl[i].r1; din1 = tbl[i].d1;
      wait_for(6, 3, "tbl_ack", ok, ta);
      if (ok != 0) begin
        chk("tbl_ack_latency", ta - (cyc - 1), 1);
        chk("tbl_ack1", {31'd0, ack1}, tbl[i].exp_own);
        chk("tbl_owner", {31'd0, owner}, tbl[i].exp_own);
        capture(0, frame, oe_cnt, done_t, done_who, extra);
        chk("tbl_frame", {22'd0, frame}, {22'd0, 1'b1, tbl[i].exp_byte, 1'b0});
        chk("tbl_oe_cycles", oe_cnt, 40);
        chk("tbl_done_latency", done_t, F);
        chk("tbl_done_who", done_who, tbl[i].exp_own);
        chk("tbl_extra_ack", extra, 0);
      end
    end

    // Tie alternation and done-to-ack spacing
    do_reset();
    req0 = 1'b1; din0 = 8'h11; req1 = 1'b1; din1 = 8'h22;
    wait_for(6, 3, "tie_ack", ok, ta);
    chk("tie_first_ack0", {31'd0, ack0}, 1);
    req0 = 1'b0;
    wait_for(2, F + 4, "tie_done0", ok, td);
    chk("tie_done0_latency", td - ta, F);
    wait_for(1, 10, "tie_ack1", ok, ta2);
    chk("tie_ack1_after_done", ta2 - td, 2);
    chk("tie_owner1", {31'd0, owner}, 1);
    req1 = 1'b0;
    wait_for(3, F + 4, "tie_done1", ok, td2);
    chk("tie_done1_latency", td2 - ta2, F);
    req0 = 1'b1; req1 = 1'b1;
    wait_for(6, 5, "tie_again", ok, ta);
    chk("tie_alternates_to_0", {30'd0, ack0, ack1}, 2);

    // rx_busy gating
    do_reset();
    rx_busy = 1'b1; req1 = 1'b1; din1 = 8'h5A;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ack1 || line_oe || busy) cnt++;
    end
    chk("rxbusy_blocked", cnt, 0);
    rx_busy = 1'b0;
    step();
    chk("rxbusy_release_ack1", {31'd0, ack1}, 1);
    req1 = 1'b0;

    // Reset mid-frame
    do_reset();
    req0 = 1'b1; din0 = 8'h5A;
    wait_for(0, 3, "rst_ack0", ok, ta);
    req0 = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("rst_midframe_busy", {30'd0, busy, line_oe}, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_midframe_outs", {24'd0, outs()}, 32'h08);
    cnt = 0;
    for (int i = 0; i < F + 8; i++) begin
      step();
      if (done0 || done1 || line_oe) cnt++;
    end
    chk("rst_no_done", cnt, 0);
    req0 = 1'b1; req1 = 1'b1;
    wait_for(6, 3, "rst_tie", ok, ta);
    chk("rst_tie_to_0", {30'd0, ack0, ack1}, 2);

    // Dropped request and din change after ack
    do_reset();
    req0 = 1'b1; din0 = 8'hC3;
    wait_for(0, 3, "latch_ack0", ok, ta);
    din0 = 8'h00;
    req0 = 1'b0;
    req1 = 1'b1;
    capture(5, frame, oe_cnt, done_t, done_who, extra);
    chk("latch_frame", {22'd0, frame}, {22'd0, 1'b1, 8'hC3, 1'b0});
    chk("latch_done_who", done_who, 0);
    chk("drop_no_ack", extra, 0);
    cnt = 0;
    for (int i = 0; i < F + 8; i++) begin
      step();
      if (ack0 || ack1 || done0 || done1) cnt++;
    end
    chk("drop_no_activity", cnt, 0);

    // Random stimulus against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic nr, n0, n1, nb;
      logic [7:0] nd0, nd1;
      chk("rand_outs", {24'd0, outs()}, {24'd0, model_out()});
      nr = ($urandom_range(0, 299) == 0);
      nb = rx_busy;
      if ($urandom_range(0, 19) == 0) nb = ~rx_busy;
      n0 = req0; nd0 = din0;
      if (!req0) begin
        if ($urandom_range(0, 7) == 0) begin
          n0 = 1'b1;
          nd0 = 8'($urandom);
        end
      end else if ($urandom_range(0, 29) == 0 || (ack0 && $urandom_range(0, 1) == 0)) begin
        n0 = 1'b0;
      end
      n1 = req1; nd1 = din1;
      if (!req1) begin
        if ($urandom_range(0, 7) == 0) begin
          n1 = 1'b1;
          nd1 = 8'($urandom);
        end
      end else if ($urandom_range(0, 29) == 0 || (ack1 && $urandom_range(0, 1) == 0)) begin
        n1 = 1'b0;
      end
      rst = nr; rx_busy = nb; req0 = n0; din0 = nd0; req1 = n1; din1 = nd1;
      model_adv(nr, n0, n1, nd0, nd1, nb);
      step();
    end
    rst = 1'b0;

    // Zero-guard instance: continuous frames from a held request
    do_reset();
    b_req0 = 1'b1; b_din0 = 8'hFF;
    wait_for(4, 3, "g0_ack", ok, ta);
    td = -1; ta2 = -1; gap = 0;
    for (int k = 0; k < 2 * F0 && ta2 < 0; k++) begin
      step();
      if (b_done0 && td < 0) td = cyc;
      if (td >= 0 && !b_line_oe) gap++;
      if (b_ack0 && td >= 0) ta2 = cyc;
    end
    chk("g0_done_latency", td - ta, F0);
    chk("g0_next_ack", ta2 - td, 2);
    chk("g0_oe_gap", {31'd0, (gap >= 1)}, 1);
    wait_for(5, F0 + 4, "g0_done2", ok, td2);
    chk("g0_done2_latency", td2 - ta2, F0);
    b_req0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
